// File: rtl/sram_access_ctrl.sv
// Read-modify-write access controller for a set/way SRAM with byte-masked writes.
// Optional power-up array clear is compiled in with SRAM_ACCESS_CTRL_INIT_EN.
module sram_access_ctrl #(
  parameter int GEN_WIDTH = 32,
  parameter int NUM_SET   = 32,
  parameter int NUM_WAY   = 2,
  parameter int SET_DEPTH = 5,
  parameter int WAY_DEPTH = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           req_valid_i,
  output logic                           req_ready_o,
  input  logic                           req_op_i,
  input  logic [SET_DEPTH-1:0]           req_set_i,
  input  logic [WAY_DEPTH-1:0]           req_way_i,
  input  logic [GEN_WIDTH-1:0]           req_wdata_i,
  input  logic [GEN_WIDTH/8-1:0]         req_bmask_i,
  output logic                           resp_valid_o,
  output logic [GEN_WIDTH-1:0]           resp_data_o,
  output logic                           init_done_o,
  output logic                           r_req_valid_o,
  output logic [SET_DEPTH-1:0]           r_req_setid_o,
  input  logic [NUM_WAY*GEN_WIDTH-1:0]   r_resp_data_i,
  output logic                           w_req_valid_o,
  output logic [SET_DEPTH-1:0]           w_req_setid_o,
  output logic [NUM_WAY-1:0]             w_req_waymask_o,
  output logic [NUM_WAY*GEN_WIDTH-1:0]   w_req_data_o
);

  localparam int NUM_BYTE = GEN_WIDTH / 8;

`ifdef SRAM_ACCESS_CTRL_INIT_EN
  typedef enum logic [2:0] {S_INIT, S_IDLE, S_RD, S_MRG, S_WR} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_RD, S_MRG, S_WR} state_t;
`endif

  state_t                         r_state;
  state_t                         w_state_nxt;
  logic                           r_init_done;
  logic                           r_op;
  logic [SET_DEPTH-1:0]           r_set;
  logic [WAY_DEPTH-1:0]           r_way;
  logic [GEN_WIDTH-1:0]           r_wdata;
  logic [NUM_BYTE-1:0]            r_bmask;
  logic [GEN_WIDTH-1:0]           r_merged;
  logic [SET_DEPTH-1:0]           r_wsetid_q;
  logic [NUM_WAY-1:0]             r_wmask_q;
  logic [NUM_WAY*GEN_WIDTH-1:0]   r_wdata_q;
  logic [GEN_WIDTH-1:0]           r_resp_q;
  logic                           w_accept;
  logic [GEN_WIDTH-1:0]           w_old;
  logic [GEN_WIDTH-1:0]           w_merged;
  logic [NUM_WAY-1:0]             w_onehot;
`ifdef SRAM_ACCESS_CTRL_INIT_EN
  logic [SET_DEPTH-1:0]           r_init_cnt;
  logic                           w_init_last;

  assign w_init_last = (r_init_cnt == SET_DEPTH'(NUM_SET - 1));
`endif

  assign w_accept      = req_valid_i && req_ready_o;
  assign init_done_o   = r_init_done;
  assign r_req_setid_o = r_set;

  always_comb begin
    w_old = '0;
    for (int unsigned k = 0; k < NUM_WAY; k++) begin
      if (r_way == WAY_DEPTH'(k)) w_old = r_resp_data_i[GEN_WIDTH*k +: GEN_WIDTH];
    end
  end

  always_comb begin
    w_merged = w_old;
    for (int unsigned b = 0; b < NUM_BYTE; b++) begin
      if (r_bmask[b]) w_merged[8*b +: 8] = r_wdata[8*b +: 8];
    end
  end

  always_comb begin
    w_onehot = '0;
    for (int unsigned k = 0; k < NUM_WAY; k++) begin
      w_onehot[k] = (r_way == WAY_DEPTH'(k));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
`ifdef SRAM_ACCESS_CTRL_INIT_EN
      S_INIT:  if (w_init_last) w_state_nxt = S_IDLE;
`endif
      S_IDLE: begin
        if (w_accept) w_state_nxt = S_RD;
`ifdef SRAM_ACCESS_CTRL_INIT_EN
        else if (!r_init_done) w_state_nxt = S_INIT;
`endif
      end
      S_RD:    w_state_nxt = S_MRG;
      S_MRG:   w_state_nxt = r_op ? S_WR : S_IDLE;
      S_WR:    w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Inactive cycles replay the *_q copies so setid/data outputs hold their last value.
  always_comb begin
    req_ready_o     = (r_state == S_IDLE) && r_init_done;
    r_req_valid_o   = (r_state == S_RD);
    w_req_valid_o   = 1'b0;
    w_req_setid_o   = r_wsetid_q;
    w_req_waymask_o = r_wmask_q;
    w_req_data_o    = r_wdata_q;
    resp_valid_o    = 1'b0;
    resp_data_o     = r_resp_q;
    unique case (r_state)
`ifdef SRAM_ACCESS_CTRL_INIT_EN
      S_INIT: begin
        w_req_valid_o   = 1'b1;
        w_req_setid_o   = r_init_cnt;
        w_req_waymask_o = '1;
        w_req_data_o    = '0;
      end
`endif
      S_MRG: begin
        if (!r_op) begin
          resp_valid_o = 1'b1;
          resp_data_o  = w_old;
        end
      end
      S_WR: begin
        w_req_valid_o   = 1'b1;
        w_req_setid_o   = r_set;
        w_req_waymask_o = w_onehot;
        w_req_data_o    = {NUM_WAY{r_merged}};
        resp_valid_o    = 1'b1;
        resp_data_o     = r_merged;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op       <= 1'b0;
      r_set      <= '0;
      r_way      <= '0;
      r_wdata    <= '0;
      r_bmask    <= '0;
      r_merged   <= '0;
      r_wsetid_q <= '0;
      r_wmask_q  <= '0;
      r_wdata_q  <= '0;
      r_resp_q   <= '0;
    end else begin
      if (w_accept) begin
        r_op    <= req_op_i;
        r_set   <= req_set_i;
        r_way   <= req_way_i;
        r_wdata <= req_wdata_i;
        r_bmask <= req_bmask_i;
      end
      if (r_state == S_MRG) r_merged <= w_merged;
      r_wsetid_q <= w_req_setid_o;
      r_wmask_q  <= w_req_waymask_o;
      r_wdata_q  <= w_req_data_o;
      r_resp_q   <= resp_data_o;
    end
  end

`ifdef SRAM_ACCESS_CTRL_INIT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_init_cnt  <= '0;
      r_init_done <= 1'b0;
    end else if (r_state == S_INIT) begin
      r_init_cnt <= w_init_last ? '0 : r_init_cnt + 1'b1;
      if (w_init_last) r_init_done <= 1'b1;
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_init_done <= 1'b0;
    else        r_init_done <= 1'b1;
  end
`endif

endmodule
